// File: rtl/mlp_eval_scheduler.sv
// -----------------------------------------------------------------------------
// mlp_eval_scheduler
//
// Sequences one evaluation run of an MLP classifier over NUM_CASES test
// samples. For every sample it issues H_STEPS hidden-layer steps and then
// O_STEPS output-layer steps to the datapath. Each step is a req/ack
// handshake. After the last step it waits for the argmax result and scores
// it against the reference label. When the last sample has been scored it
// emits a one-cycle done pulse.
//
// Optional feature:
//   MLP_SCHED_TIMEOUT_EN - when defined, an 8-bit watchdog guards each step.
//                          A step that is not acknowledged in time ends the
//                          run and raises the sticky err flag. When it is
//                          undefined, the block waits indefinitely for
//                          step_ack and err is tied low.
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   start        in   1       level; only sampled in IDLE
//   abort        in   1       synchronous abort of a run in progress
//   step_req     out  1       request to the datapath to run the current step
//   step_ack     in   1       datapath has completed the requested step
//   layer_sel    out  3       current step index (0 outside a step)
//   bank_en      out  32      neuron-register load enables for the step
//   sample_addr  out  ADDR_W  current test-sample address
//   pred_valid   in   1       argmax result valid
//   pred_label   in   4       predicted class
//   true_label   in   4       reference class for sample_addr
//   correct_cnt  out  ADDR_W  correctly classified samples (saturating)
//   busy         out  1       high in every state except IDLE
//   done         out  1       one-cycle pulse at the end of a run
//   err          out  1       sticky step-timeout flag
// -----------------------------------------------------------------------------
module mlp_eval_scheduler #(
    parameter int NUM_CASES = 750,
    parameter int ADDR_W    = 10,
    parameter int H_STEPS   = 4,
    parameter int O_STEPS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              step_req,
    input  logic              step_ack,
    output logic [2:0]        layer_sel,
    output logic [31:0]       bank_en,
    output logic [ADDR_W-1:0] sample_addr,
    input  logic              pred_valid,
    input  logic [3:0]        pred_label,
    input  logic [3:0]        true_label,
    output logic [ADDR_W-1:0] correct_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int              TOTAL_STEPS = H_STEPS + O_STEPS;
    localparam logic [2:0]      LAST_STEP   = 3'(TOTAL_STEPS - 1);
    localparam logic [2:0]      H_STEPS_W   = 3'(H_STEPS);
    localparam logic [2:0]      LAST_OUT    = 3'(O_STEPS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CASES - 1);
    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

    // The output layer has 10 neurons. Every output step but the last loads a
    // full byte of registers. The last step loads only the neurons that are
    // left over, clamped to the range of one byte.
    localparam int LAST_BITS_RAW = 10 - 8 * (O_STEPS - 1);
    localparam int LAST_BITS     = (LAST_BITS_RAW > 8) ? 8 :
                                   ((LAST_BITS_RAW < 0) ? 0 : LAST_BITS_RAW);
    localparam logic [7:0] LAST_BYTE = 8'((16'd1 << LAST_BITS) - 16'd1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        SCORE,
        NEXT,
        FINISH
    } state_t;

    state_t              state, state_next;
    logic [2:0]          step_cnt, step_next;
    logic [ADDR_W-1:0]   addr_next;
    logic [ADDR_W-1:0]   cnt_next;
    logic                timeout;
    logic                in_step;

    // Load-enable pattern for step k. Hidden steps walk a byte-wide window
    // across the word. Output steps restart at byte 0, and the final output
    // step enables only the remaining output neurons.
    function automatic logic [31:0] step_mask(input logic [2:0] k);
        logic [2:0]  j;
        logic [31:0] mask;
        j = k - H_STEPS_W;
        if (k < H_STEPS_W) begin
            mask = 32'h0000_00FF << {k, 3'b000};
        end else if (j == LAST_OUT) begin
            mask = {24'd0, LAST_BYTE} << {j, 3'b000};
        end else begin
            mask = 32'h0000_00FF << {j, 3'b000};
        end
        return mask;
    endfunction

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop is
    // reset here, so reset returns the block to IDLE with zeroed counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step_cnt    <= '0;
            sample_addr <= '0;
            correct_cnt <= '0;
        end else begin
            state       <= state_next;
            step_cnt    <= step_next;
            sample_addr <= addr_next;
            correct_cnt <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first. A path that does
    // not assign a signal would otherwise infer a latch.
    always_comb begin
        state_next = state;
        step_next  = step_cnt;
        addr_next  = sample_addr;
        cnt_next   = correct_cnt;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    step_next  = '0;
                    addr_next  = '0;
                    cnt_next   = '0;
                end
            end

            // An ack in the ISSUE cycle is as good as one in WAIT_ACK, so a
            // datapath that holds step_ack high completes one step per cycle.
            // Abort wins over a simultaneous ack.
            ISSUE, WAIT_ACK: begin
                if (abort) begin
                    state_next = FINISH;
                end else if (step_ack) begin
                    step_next  = step_cnt + 3'd1;
                    state_next = (step_cnt == LAST_STEP) ? SCORE : ISSUE;
                end else if (timeout) begin
                    state_next = FINISH;
                end else begin
                    state_next = WAIT_ACK;
                end
            end

            SCORE: begin
                if (abort) begin
                    state_next = FINISH;
                end else if (pred_valid) begin
                    if ((pred_label == true_label) && (correct_cnt != CNT_MAX)) begin
                        cnt_next = correct_cnt + 1'b1;
                    end
                    state_next = NEXT;
                end
            end

            NEXT: begin
                if (abort || (sample_addr == LAST_ADDR)) begin
                    state_next = FINISH;
                end else begin
                    addr_next  = sample_addr + 1'b1;
                    step_next  = '0;
                    state_next = ISSUE;
                end
            end

            // The block is already finishing, so abort has nothing left to
            // cut short. FINISH always lasts exactly one cycle.
            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state only. They therefore fall
    // to zero together with the state when an asynchronous reset occurs.
    assign in_step   = (state == ISSUE) || (state == WAIT_ACK);
    assign step_req  = in_step;
    assign layer_sel = in_step ? step_cnt : 3'd0;
    assign bank_en   = in_step ? step_mask(step_cnt) : 32'd0;
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);

    // -------------------------------------------------------------------------
    // Step watchdog
    // -------------------------------------------------------------------------
`ifdef MLP_SCHED_TIMEOUT_EN
    logic [7:0] wdog;
    logic       err_q;

    // The watchdog is zero in ISSUE and counts every WAIT_ACK cycle. The
    // timeout fires on the WAIT_ACK cycle in which the count would reach 255.
    // FINISH therefore starts 256 cycles after the ISSUE cycle of the step
    // that stalled.
    assign timeout = (state == WAIT_ACK) && !step_ack && (wdog == 8'd254);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            wdog <= (state == WAIT_ACK) ? wdog + 8'd1 : 8'd0;
            if ((state == IDLE) && start) begin
                err_q <= 1'b0;
            end else if (timeout && !abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_eval_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mlp_eval_scheduler
//
// Directed bench for mlp_eval_scheduler with NUM_CASES=3, H_STEPS=4 and
// O_STEPS=2. The bench plays the role of the datapath with a linear script.
// It acknowledges steps, supplies prediction and reference labels, and
// checks the scheduler outputs one cycle after each rising edge of clk.
// The timeout scenario follows MLP_SCHED_TIMEOUT_EN in the same way as the
// design.
// -----------------------------------------------------------------------------
module tb_mlp_eval_scheduler;

    localparam int NUM_CASES = 3;
    localparam int ADDR_W    = 2;
    localparam int H_STEPS   = 4;
    localparam int O_STEPS   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              step_ack = 1'b0;
    logic              pred_valid = 1'b0;
    logic [3:0]        pred_label = 4'd0;
    logic [3:0]        true_label = 4'd0;
    logic              step_req;
    logic [2:0]        layer_sel;
    logic [31:0]       bank_en;
    logic [ADDR_W-1:0] sample_addr;
    logic [ADDR_W-1:0] correct_cnt;
    logic              busy;
    logic              done;
    logic              err;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    // Hand-computed load enables for steps 0..5 (4 hidden, 2 output; the last
    // output step covers neurons 8 and 9 only).
    logic [31:0] bank_tbl [6] = '{32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000,
                                  32'hFF00_0000, 32'h0000_00FF, 32'h0000_0300};

    mlp_eval_scheduler #(
        .NUM_CASES (NUM_CASES),
        .ADDR_W    (ADDR_W),
        .H_STEPS   (H_STEPS),
        .O_STEPS   (O_STEPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .step_req    (step_req),
        .step_ack    (step_ack),
        .layer_sel   (layer_sel),
        .bank_en     (bank_en),
        .sample_addr (sample_addr),
        .pred_valid  (pred_valid),
        .pred_label  (pred_label),
        .true_label  (true_label),
        .correct_cnt (correct_cnt),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Counts done pulses and accepted step handshakes.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if ((step_req === 1'b1) && (step_ack === 1'b1)) hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits up to 20 cycles for step_req. If the wait runs out, the check
    // fails and the script continues.
    task automatic wait_req(input string tag);
        int n = 0;
        while ((step_req !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        check(tag, step_req, 32'd1);
    endtask

    // Runs all six steps of one sample. Step stall_step is held in WAIT_ACK
    // for stall_len cycles. The sample is then scored with matching or
    // differing labels.
    task automatic run_sample(input int idx, input int stall_step, input int stall_len,
                              input bit match);
        for (int k = 0; k < 6; k++) begin
            wait_req("step_req_rise");
            check("layer_sel", layer_sel, k);
            check("bank_en", bank_en, bank_tbl[k]);
            if (k == 0) check("sample_addr", sample_addr, idx);
            if (k == stall_step) begin
                for (int c = 0; c < stall_len; c++) begin
                    tick();
                    check("stall_step_req", step_req, 32'd1);
                    check("stall_layer_sel", layer_sel, k);
                    check("stall_bank_en", bank_en, bank_tbl[k]);
                end
            end
            step_ack = 1'b1;
            tick();
            step_ack = 1'b0;
        end
        check("score_step_req", step_req, 32'd0);
        check("score_bank_en", bank_en, 32'd0);
        check("score_busy", busy, 32'd1);
        tick();
        check("score_wait_req", step_req, 32'd0);
        pred_label = 4'(idx + 3);
        true_label = match ? 4'(idx + 3) : 4'(idx + 9);
        pred_valid = 1'b1;
        tick();
        pred_valid = 1'b0;
    endtask

    // Called with the block in NEXT after the last sample has been scored.
    task automatic finish_check(input int exp_cnt, input int exp_addr);
        check("next_done", done, 32'd0);
        tick();
        check("finish_done", done, 32'd1);
        check("finish_addr", sample_addr, exp_addr);
        check("finish_cnt", correct_cnt, exp_cnt);
        check("finish_step_req", step_req, 32'd0);
        tick();
        check("idle_done", done, 32'd0);
        check("idle_busy", busy, 32'd0);
        tick();
        tick();
        check("idle_hold_cnt", correct_cnt, exp_cnt);
        check("idle_hold_addr", sample_addr, exp_addr);
    endtask

    int d0;
    int h0;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        #12;
        check("rst_step_req", step_req, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_bank_en", bank_en, 32'd0);
        check("rst_layer_sel", layer_sel, 32'd0);
        check("rst_addr", sample_addr, 32'd0);
        check("rst_cnt", correct_cnt, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_no_start", busy, 32'd0);

        // ---------------- A: full run, immediate ack, all correct ----------------
        d0 = done_cnt;
        h0 = hs_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("A_busy", busy, 32'd1);
        run_sample(0, -1, 0, 1'b1);
        run_sample(1, -1, 0, 1'b1);
        run_sample(2, -1, 0, 1'b1);
        finish_check(3, 2);
        check("A_handshakes", hs_cnt - h0, 32'd18);
        check("A_done_pulses", done_cnt - d0, 32'd1);

        // ---------------- B: stall on step 2, mismatches on samples 0 and 2 ----------------
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("B_cnt_cleared", correct_cnt, 32'd0);
        check("B_addr_cleared", sample_addr, 32'd0);
        run_sample(0, 2, 5, 1'b0);
        start = 1'b1;                  // must be ignored while busy
        run_sample(1, -1, 0, 1'b1);
        start = 1'b0;
        run_sample(2, -1, 0, 1'b0);
        finish_check(1, 2);
        check("B_done_pulses", done_cnt - d0, 32'd1);

        // ---------------- C: abort with simultaneous ack in sample 1 ----------------
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sample(0, -1, 0, 1'b1);
        wait_req("C_s1_req");
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        tick();
        check("C_wait_layer", layer_sel, 32'd1);
        abort      = 1'b1;
        step_ack   = 1'b1;
        pred_valid = 1'b1;
        pred_label = 4'd7;
        true_label = 4'd7;
        tick();
        abort      = 1'b0;
        step_ack   = 1'b0;
        pred_valid = 1'b0;
        check("C_done", done, 32'd1);
        check("C_step_req", step_req, 32'd0);
        check("C_cnt", correct_cnt, 32'd1);
        check("C_addr", sample_addr, 32'd1);
        check("C_bank_en", bank_en, 32'd0);
        tick();
        check("C_idle_done", done, 32'd0);
        check("C_idle_busy", busy, 32'd0);
        check("C_done_pulses", done_cnt - d0, 32'd1);

        // ---------------- D: async reset mid WAIT_ACK, then fresh run ----------------
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sample(0, -1, 0, 1'b1);
        wait_req("D_s1_req");
        tick();
        check("D_in_wait", step_req, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("D_rst_step_req", step_req, 32'd0);
        check("D_rst_busy", busy, 32'd0);
        check("D_rst_bank_en", bank_en, 32'd0);
        check("D_rst_layer_sel", layer_sel, 32'd0);
        check("D_rst_addr", sample_addr, 32'd0);
        check("D_rst_cnt", correct_cnt, 32'd0);
        check("D_rst_err", err, 32'd0);
        check("D_rst_done", done, 32'd0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        tick();
        check("D_no_done", done_cnt - d0, 32'd0);
        check("D_idle", busy, 32'd0);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_sample(0, -1, 0, 1'b1);
        run_sample(1, -1, 0, 1'b0);
        run_sample(2, -1, 0, 1'b1);
        finish_check(2, 2);
        check("D_done_pulses", done_cnt - d0, 32'd1);

        // ---------------- E: step_ack never arrives ----------------
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("E_issue", step_req, 32'd1);
`ifdef MLP_SCHED_TIMEOUT_EN
        repeat (255) tick();
        check("E_pre_timeout_req", step_req, 32'd1);
        check("E_pre_timeout_done", done, 32'd0);
        check("E_pre_timeout_err", err, 32'd0);
        tick();
        check("E_timeout_done", done, 32'd1);
        check("E_timeout_err", err, 32'd1);
        check("E_timeout_req", step_req, 32'd0);
        tick();
        check("E_idle_err", err, 32'd1);
        check("E_idle_busy", busy, 32'd0);
        tick();
        check("E_err_sticky", err, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("E_err_cleared", err, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("E_abort_done", done, 32'd1);
        tick();
        check("E_done_pulses", done_cnt - d0, 32'd2);
`else
        repeat (300) tick();
        check("E_still_waiting", step_req, 32'd1);
        check("E_still_busy", busy, 32'd1);
        check("E_err_tied", err, 32'd0);
        check("E_no_done", done_cnt - d0, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("E_abort_done", done, 32'd1);
        tick();
        check("E_abort_idle", busy, 32'd0);
        check("E_done_pulses", done_cnt - d0, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_eval_scheduler.md
MLP_EVAL_SCHEDULER -- requirements
Module: mlp_eval_scheduler

Interface
REQ-001 SHALL have parameter NUM_CASES, default 750: number of test samples per run.
REQ-002 SHALL have parameter ADDR_W, default 10: sample address and counter width, ceil(log2(NUM_CASES)).
REQ-003 SHALL have parameter H_STEPS, default 4: hidden-layer steps per sample.
REQ-004 SHALL have parameter O_STEPS, default 2: output-layer steps per sample; H_STEPS+O_STEPS <= 8.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  level; sampled only in IDLE.
REQ-008 SHALL have port abort  in  1  synchronous abort of a run in progress.
REQ-009 SHALL have port step_req  out  1  request to datapath to execute the current step.
REQ-010 SHALL have port step_ack  in  1  datapath has completed the requested step.
REQ-011 SHALL have port layer_sel  out  3  current step index, 0..H_STEPS+O_STEPS-1.
REQ-012 SHALL have port bank_en  out  32  neuron-register load enables for the current step.
REQ-013 SHALL have port sample_addr  out  ADDR_W  current test-sample address.
REQ-014 SHALL have port pred_valid  in  1  argmax result valid.
REQ-015 SHALL have port pred_label  in  4  predicted class.
REQ-016 SHALL have port true_label  in  4  reference class for sample_addr.
REQ-017 SHALL have port correct_cnt  out  ADDR_W  number of correctly classified samples.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.
REQ-019 SHALL have port done  out  1  single-cycle pulse at end of run.
REQ-020 SHALL have port err  out  1  sticky step-timeout flag.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT_ACK, SCORE, NEXT and FINISH.
REQ-022 SHALL transition IDLE->ISSUE when start=1, clearing sample_addr, correct_cnt, err and the step counter on that edge.
REQ-023 SHALL, in ISSUE, assert step_req for one cycle and then go to WAIT_ACK.
REQ-024 SHALL, in WAIT_ACK, hold step_req=1 until step_ack=1.
REQ-025 SHALL, when step_ack is seen, advance the step counter and go to ISSUE if steps remain, otherwise to SCORE.
REQ-026 SHALL treat step_ack outside WAIT_ACK/ISSUE as ignored; step_ack in the ISSUE cycle counts as an ack.
REQ-027 SHALL drive layer_sel equal to the step counter in ISSUE and WAIT_ACK, and 0 elsewhere.
REQ-028 SHALL set bank_en for hidden step k (k<H_STEPS) to bits [8k+7:8k] = 8'hFF.
REQ-029 SHALL set bank_en for output step j = k-H_STEPS to bits [8j+7:8j] = 8'hFF, except the final output step, which SHALL enable only the low (10 - 8*(O_STEPS-1)) bits of its byte.
REQ-030 SHALL keep bank_en = 0 outside ISSUE and WAIT_ACK.
REQ-031 SHALL, in SCORE, wait for pred_valid=1.
REQ-032 SHALL increment correct_cnt (saturating at all-ones) on that cycle when pred_label==true_label, then go to NEXT.
REQ-033 SHALL, in NEXT, go to FINISH when sample_addr == NUM_CASES-1.
REQ-034 SHALL otherwise, in NEXT, increment sample_addr, clear the step counter and go to ISSUE.
REQ-035 SHALL, in FINISH, pulse done=1 for one cycle and return to IDLE.
REQ-036 SHALL hold correct_cnt and sample_addr stable in IDLE until the next start.
REQ-037 SHALL, when abort=1 in any non-IDLE state, go to FINISH next cycle with step_req=0 and correct_cnt unchanged.
REQ-038 SHALL give abort priority over step_ack and pred_valid in the same cycle.
REQ-039 SHALL ignore start while busy.

Reset
REQ-040 SHALL, on rst=1 (asynchronous), go to IDLE and force step_req, done, err, busy, bank_en, layer_sel, sample_addr and correct_cnt to 0.
REQ-041 SHALL abandon any outstanding step on reset, with no done pulse.

Configuration
REQ-042 SHALL use the macro MLP_SCHED_TIMEOUT_EN.
REQ-043 SHALL, when MLP_SCHED_TIMEOUT_EN is defined, run an 8-bit watchdog that clears on ISSUE entry and counts each WAIT_ACK cycle.
REQ-044 SHALL, when the watchdog reaches 255 with no step_ack, set err=1 and go to FINISH.
REQ-045 SHALL hold err until the next start or reset.
REQ-046 SHALL, when MLP_SCHED_TIMEOUT_EN is undefined, wait indefinitely in WAIT_ACK and tie err to 0.

Verification
REQ-047 SHALL cover a full run: NUM_CASES=3, immediate step_ack, pred_label==true_label for all -> 6 step_req per sample, correct_cnt=3, one done pulse, sample_addr=2 at done.
REQ-048 SHALL cover ack-stall and bank_en sequencing: step_ack delayed 5 cycles on step 2 -> step_req held 5 cycles, layer_sel=2 and bank_en=32'h00FF0000 throughout; step 5 bank_en=32'h00000300.
REQ-049 SHALL cover mismatches: labels differ on samples 0 and 2 of 3 -> correct_cnt=1.
REQ-050 SHALL cover abort with a simultaneous step_ack during sample 1 -> FINISH next cycle, done pulse, correct_cnt equals count from sample 0 only.
REQ-051 SHALL cover async reset mid-WAIT_ACK -> all outputs 0 immediately, no done; a fresh start runs normally.
REQ-052 SHALL cover timeout, MLP_SCHED_TIMEOUT_EN defined: step_ack never asserted -> err=1 and done pulse 256 cycles after ISSUE; undefined: err stays 0 and the block stays in WAIT_ACK.
